fetch_stage: RTL

- Instruction-fetch front end, directly upstream of the ID/EX/WB pipeline-register block.
- Owns the architectural PC, which resets to 0x2000, and issues requests to the icache over a valid/ready handshake.
- Aligns instruction responses with their PC and delivers {PC, PCplus4, inst} to ID.
- Honours downstream stall and branch/jump redirects; raises its own stall while an icache miss is outstanding.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_if.sv | 18 +
 rtl/fetch_skid_buf.sv | 31 +++
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // One fetched instruction paired with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_2000;

  // Force a redirect target onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch <-> icache request/response channel.
interface fetch_if;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_req_ready;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_data;

  modport master (
    output icache_req_valid, icache_req_addr,
    input  icache_req_ready, icache_resp_valid, icache_resp_data
  );

  modport slave (
    input  icache_req_valid, icache_req_addr,
    output icache_req_ready, icache_resp_valid, icache_resp_data
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding register for a response that arrives while
// the downstream is stalled. Flush wins over load, load over unload.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         unload,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output fetch_entry_t dout
);

  // Capture/release the single entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      dout <= '{pc: RESET_PC_DEF, inst: NOP_INST};
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, runs one icache request at a
// time, and presents {PC, PC+4, inst} to ID. Optional performance counters
// are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  fetch_if.master     ic,
  output logic [31:0] PC,
  output logic [31:0] PCplus4_ID,
  output logic [31:0] inst_ID,
  output logic        inst_valid_ID,
  output logic        fetch_stall,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] miss_cycles
`endif
);

  fetch_state_e state, next_state;
  logic [31:0]  fetch_pc;
  logic         active;      // keeps the request low until the first edge after reset
  logic         drop_flag;   // next response belongs to a squashed path
  logic         accept;
  logic         load_resp, skid_load, skid_unload, skid_flush, id_load;
  logic         skid_full;
  fetch_entry_t resp_entry, skid_out, id_entry;

  assign ic.icache_req_addr = fetch_pc;
  assign accept             = ic.icache_req_valid && ic.icache_req_ready;
  assign resp_entry         = '{pc: fetch_pc, inst: ic.icache_resp_data};
  assign id_load            = load_resp || skid_unload;
  assign id_entry           = load_resp ? resp_entry : skid_out;
  assign PCplus4_ID         = PC + PC_INC;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= REQ;
    else        state <= next_state;
  end

  // Next-state logic; a redirect always lands back in REQ except when it
  // coincides with an accepted request, whose response must still be drained.
  always_comb begin
    next_state = state;
    case (state)
      REQ:  if (accept) next_state = WAIT;
      WAIT: if (ic.icache_resp_valid) next_state = skid_load ? HOLD : REQ;
      HOLD: if (redirect_valid || !stall) next_state = REQ;
      default: next_state = REQ;
    endcase
  end

  // State-decoded outputs and datapath strobes.
  always_comb begin
    ic.icache_req_valid = 1'b0;
    fetch_stall         = 1'b0;
    load_resp           = 1'b0;
    skid_load           = 1'b0;
    skid_unload         = 1'b0;
    skid_flush          = 1'b0;
    case (state)
      REQ: ic.icache_req_valid = active;
      WAIT: begin
        fetch_stall = 1'b1;
        if (ic.icache_resp_valid && !redirect_valid && !drop_flag) begin
          if (stall) skid_load = 1'b1;
          else       load_resp = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid)          skid_flush  = 1'b1;
        else if (!stall && skid_full) skid_unload = 1'b1;
      end
      default: ;
    endcase
  end

  // First request goes out one edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) active <= 1'b0;
    else        active <= 1'b1;
  end

  // Fetch address: redirect target, else advance once per delivered instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= word_align(redirect_pc);
    else if (id_load)        fetch_pc <= fetch_pc + PC_INC;
  end

  // Drop tracking: a redirect with a request in flight marks its response stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_flag <= 1'b0;
    end else if (state == WAIT) begin
      if (ic.icache_resp_valid) drop_flag <= 1'b0;
      else if (redirect_valid)  drop_flag <= 1'b1;
    end else if (accept && redirect_valid) begin
      drop_flag <= 1'b1;
    end
  end

  // ID registers: squash on redirect, hold on stall, bubble when nothing new.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC            <= RESET_PC;
      inst_ID       <= NOP_INST;
      inst_valid_ID <= 1'b0;
    end else if (redirect_valid) begin
      inst_ID       <= NOP_INST;
      inst_valid_ID <= 1'b0;
    end else if (id_load) begin
      PC            <= id_entry.pc;
      inst_ID       <= id_entry.inst;
      inst_valid_ID <= 1'b1;
    end else if (!stall) begin
      inst_ID       <= NOP_INST;
      inst_valid_ID <= 1'b0;
    end
  end

  // Single-cycle flag for a redirect target that is not word aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_err <= 1'b0;
    else        misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end

  fetch_skid_buf u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .flush  (skid_flush),
    .din    (resp_entry),
    .full   (skid_full),
    .dout   (skid_out)
  );

`ifdef FETCH_PERF_CNT_EN
  // Delivered-instruction and miss-cycle counters, free-running and wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
      miss_cycles <= '0;
    end else begin
      if (id_load)        fetch_count <= fetch_count + 32'd1;
      if (state == WAIT)  miss_cycles <= miss_cycles + 32'd1;
    end
  end
`endif

endmodule
